// File: rtl/itch_pkg.sv
// itch_pkg: ITCH type bytes, dispatcher phase encoding and start-vector lane indices.
package itch_pkg;

    localparam logic [7:0] MSG_ADD_ORDER      = 8'h41;
    localparam logic [7:0] MSG_EXECUTED       = 8'h45;
    localparam logic [7:0] MSG_EXECUTED_PRICE = 8'h43;
    localparam logic [7:0] MSG_ORDER_DELETE   = 8'h44;
    localparam logic [7:0] MSG_REPLACE        = 8'h55;
    localparam logic [7:0] MSG_SECONDS        = 8'h54;

    localparam logic [15:0] LEN_ORDER_DELETE = 16'd18;
    localparam logic [15:0] LEN_SECONDS      = 16'd5;

    typedef enum logic [1:0] {LEN_HI, LEN_LO, TYPE, BODY} phaseT;

    localparam int START_ADD          = 0;
    localparam int START_EXECUTED     = 1;
    localparam int START_EXEC_PRICE   = 2;
    localparam int START_DELETE       = 3;
    localparam int START_REPLACE      = 4;
    localparam int START_SECONDS      = 5;
    localparam int START_OTHER        = 6;
    localparam int NUM_STARTS         = 7;

    // Fixed wire length of the message types whose size the parsers rely on; 0 when variable/unknown.
    function automatic logic [15:0] expectedLength(input logic [7:0] msgType);
        return msgType == MSG_ORDER_DELETE ? LEN_ORDER_DELETE :
               msgType == MSG_SECONDS      ? LEN_SECONDS      : 16'd0;
    endfunction

endpackage

// File: rtl/itch_message_dispatcher_if.sv
// itch_message_dispatcher_if: 64-bit word stream feeding the dispatcher.
interface itch_message_dispatcher_if;
    logic [63:0] dataIn;
    logic        inValid;
    logic        inReady;
    modport master (output dataIn, inValid, input inReady);
    modport slave  (input dataIn, inValid, output inReady);
endinterface

// File: rtl/itch_type_decoder.sv
// itch_type_decoder: maps an ITCH type byte onto a one-hot parser start vector.
module itch_type_decoder
    import itch_pkg::*;
(
    input  logic [7:0]            typeByte,
    output logic [NUM_STARTS-1:0] startVec
);

    always_comb begin
        startVec                   = '0;
        startVec[START_ADD]        = typeByte == MSG_ADD_ORDER;
        startVec[START_EXECUTED]   = typeByte == MSG_EXECUTED;
        startVec[START_EXEC_PRICE] = typeByte == MSG_EXECUTED_PRICE;
        startVec[START_DELETE]     = typeByte == MSG_ORDER_DELETE;
        startVec[START_REPLACE]    = typeByte == MSG_REPLACE;
        startVec[START_SECONDS]    = typeByte == MSG_SECONDS;
        startVec[START_OTHER]      = ~|startVec[START_SECONDS:START_ADD];
    end

endmodule

// File: rtl/itch_message_dispatcher.sv
// itch_message_dispatcher: walks length-prefixed ITCH messages in 64-bit words and pulses one parser start per type byte.
module itch_message_dispatcher
    import itch_pkg::*;
#(
    parameter int MAX_LEN = 64,
    parameter int CNT_W   = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    itch_message_dispatcher_if.slave    inBus,
    output logic [63:0]                 dataOut,
    output logic [5:0]                  trackerOut,
    output logic [15:0]                 msgLength,
    output logic                        startAddOrder,
    output logic                        startOrderExecuted,
    output logic                        startOrderExecutedPrice,
    output logic                        startOrderDelete,
    output logic                        startOrderReplace,
    output logic                        startTimeSeconds,
    output logic                        startOther,
    output logic                        lenError,
    output logic [CNT_W-1:0]            msgCount
);

    phaseT                 phase, phaseN;
    logic [2:0]            cursor, cursorN, typeIdx;
    logic [7:0]            lenHi, lenHiN, typeByte, b;
    logic [15:0]           rem, remN, typeLen;
    logic                  typeSeen, stop, lenErr, lenErrNext;
    logic [NUM_STARTS-1:0] typeVec, startNext, startReg;

    itch_type_decoder dec (.typeByte(typeByte), .startVec(typeVec));

    always_ff @(posedge clk) begin
        if (!rst) begin
            phase      <= LEN_HI;
            cursor     <= '0;
            lenHi      <= '0;
            rem        <= '0;
            startReg   <= '0;
            lenError   <= 1'b0;
            dataOut    <= '0;
            trackerOut <= '0;
            msgLength  <= '0;
            msgCount   <= '0;
        end else begin
            startReg <= startNext;
            lenError <= lenErrNext;
            if (inBus.inValid) begin
                phase  <= phaseN;
                cursor <= cursorN;
                lenHi  <= lenHiN;
                rem    <= remN;
            end
            if (typeSeen) begin
                dataOut    <= inBus.dataIn;
                trackerOut <= {3'd0, typeIdx};
                msgLength  <= typeLen;
                msgCount   <= msgCount + CNT_W'(1);
            end
        end
    end

    // Rem holds L between the length and type bytes, then counts the body down.
    always_comb begin
        phaseN   = phase;
        cursorN  = 3'd0;
        lenHiN   = lenHi;
        remN     = rem;
        typeSeen = 1'b0;
        stop     = 1'b0;
        typeIdx  = 3'd0;
        typeByte = 8'd0;
        typeLen  = 16'd0;
        lenErr   = 1'b0;
        b        = 8'd0;
        for (int i = 0; i < 8; i++) begin
            b = inBus.dataIn[63 - 8*i -: 8];
            if (inBus.inValid && !stop && 3'(i) >= cursor) begin
                case (phaseN)
                    LEN_HI: begin
                        lenHiN = b;
                        phaseN = LEN_LO;
                    end
                    LEN_LO: begin
                        remN   = {lenHiN, b};
                        lenErr = lenErr | (remN == '0) | (remN > 16'(MAX_LEN));
                        phaseN = remN == '0 ? LEN_HI : TYPE;
                    end
                    TYPE: begin
                        if (typeSeen) begin
                            stop    = 1'b1;
                            cursorN = 3'(i);
                        end else begin
                            typeSeen = 1'b1;
                            typeIdx  = 3'(i);
                            typeByte = b;
                            typeLen  = remN;
                            remN     = remN - 16'd1;
                            phaseN   = remN == '0 ? LEN_HI : BODY;
                        end
                    end
                    default: begin
                        remN   = remN - 16'd1;
                        phaseN = remN == '0 ? LEN_HI : BODY;
                    end
                endcase
            end
        end
    end

    always_comb begin
        inBus.inReady = inBus.inValid && !stop;
        startNext     = typeSeen ? typeVec : '0;
        lenErrNext    = lenErr;
    end

    assign startAddOrder           = startReg[START_ADD];
    assign startOrderExecuted      = startReg[START_EXECUTED];
    assign startOrderExecutedPrice = startReg[START_EXEC_PRICE];
    assign startOrderDelete        = startReg[START_DELETE];
    assign startOrderReplace       = startReg[START_REPLACE];
    assign startTimeSeconds        = startReg[START_SECONDS];
    assign startOther              = startReg[START_OTHER];

endmodule

// File: tb/tb_itch_message_dispatcher.sv
// tb_itch_message_dispatcher: byte-stream reference model feeding a scoreboard checked by an output monitor.
module tb_itch_message_dispatcher;
    import itch_pkg::*;

    localparam int MAX_LEN = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    itch_message_dispatcher_if bus();

    logic [63:0] dataOut;
    logic [5:0]  trackerOut;
    logic [15:0] msgLength;
    logic        startAddOrder, startOrderExecuted, startOrderExecutedPrice, startOrderDelete;
    logic        startOrderReplace, startTimeSeconds, startOther, lenError;
    logic [31:0] msgCount;

    itch_message_dispatcher #(.MAX_LEN(MAX_LEN), .CNT_W(32)) dut (
        .clk(clk),
        .rst(rst),
        .inBus(bus),
        .dataOut(dataOut),
        .trackerOut(trackerOut),
        .msgLength(msgLength),
        .startAddOrder(startAddOrder),
        .startOrderExecuted(startOrderExecuted),
        .startOrderExecutedPrice(startOrderExecutedPrice),
        .startOrderDelete(startOrderDelete),
        .startOrderReplace(startOrderReplace),
        .startTimeSeconds(startTimeSeconds),
        .startOther(startOther),
        .lenError(lenError),
        .msgCount(msgCount)
    );

    typedef struct {
        logic [6:0]  starts;
        logic        lenErr;
        logic [5:0]  tracker;
        logic [63:0] word;
        logic [15:0] len;
        logic [31:0] cnt;
    } evT;

    evT          expQ[$];
    logic [7:0]  byteQ[$];
    bit          typeQ[$];
    bit          errQ[$];
    logic [15:0] lenQ[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] expCnt = 0;

    // Bit order: A, E, C, D, U, T, other.
    function automatic logic [6:0] startsFor(input logic [7:0] t);
        case (t)
            8'h41:   return 7'b0000001;
            8'h45:   return 7'b0000010;
            8'h43:   return 7'b0000100;
            8'h44:   return 7'b0001000;
            8'h55:   return 7'b0010000;
            8'h54:   return 7'b0100000;
            default: return 7'b1000000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pushByte(input logic [7:0] v, input bit t, input bit e, input logic [15:0] l);
        byteQ.push_back(v);
        typeQ.push_back(t);
        errQ.push_back(e);
        lenQ.push_back(l);
    endtask

    task automatic addMsg(input int len, input logic [7:0] typ);
        pushByte(8'(len >> 8), 0, 0, 0);
        pushByte(8'(len), 0, len == 0 || len > MAX_LEN, 0);
        if (len > 0) begin
            pushByte(typ, 1, 0, 16'(len));
            for (int i = 1; i < len; i++) pushByte(8'($urandom), 0, 0, 0);
        end
    endtask

    task automatic padStream();
        int r;
        r = (8 - byteQ.size() % 8) % 8;
        if (r >= 3) addMsg(r - 2, 8'h5A);
        else if (r > 0) addMsg(r + 6, 8'h5A);
    endtask

    // One DUT cycle per type byte in the word (at least one); each cycle spans from its type byte to the next.
    task automatic driveWord(input int w);
        logic [63:0] word;
        int          tpos[$];
        int          nseg, lo, hi, cyc;
        bit          rdy;
        evT          e;
        for (int j = 0; j < 8; j++) begin
            word[63 - 8*j -: 8] = byteQ[8*w + j];
            if (typeQ[8*w + j]) tpos.push_back(j);
        end
        nseg = tpos.size() > 0 ? tpos.size() : 1;
        for (int k = 0; k < nseg; k++) begin
            lo = k == 0 ? 0 : tpos[k];
            hi = k + 1 < tpos.size() ? tpos[k+1] - 1 : 7;
            e.lenErr = 0;
            for (int j = lo; j <= hi; j++) e.lenErr |= errQ[8*w + j];
            e.starts  = k < tpos.size() ? startsFor(byteQ[8*w + tpos[k]]) : 7'd0;
            e.tracker = k < tpos.size() ? 6'(tpos[k]) : 6'd0;
            e.len     = k < tpos.size() ? lenQ[8*w + tpos[k]] : 16'd0;
            e.word    = word;
            if (e.starts != 0) expCnt++;
            e.cnt = expCnt;
            if (e.starts != 0 || e.lenErr) expQ.push_back(e);
        end
        if ($urandom_range(0, 3) == 0) begin
            bus.inValid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        bus.dataIn  = word;
        bus.inValid = 1'b1;
        cyc = 0;
        do begin
            #1 rdy = bus.inReady;
            cyc++;
            @(negedge clk);
        end while (!rdy && cyc < 20);
        chk("cyclesPerWord", 64'(cyc), 64'(nseg));
    endtask

    task automatic driveAll(input int limit);
        int n;
        n = byteQ.size() / 8;
        if (limit < n) n = limit;
        for (int w = 0; w < n; w++) driveWord(w);
        bus.inValid = 1'b0;
        byteQ.delete();
        typeQ.delete();
        errQ.delete();
        lenQ.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic chkIdle(input string tag);
        chk({tag, "_starts"}, 64'({startOther, startTimeSeconds, startOrderReplace, startOrderDelete,
                                   startOrderExecutedPrice, startOrderExecuted, startAddOrder}), 0);
        chk({tag, "_lenError"}, 64'(lenError), 0);
        chk({tag, "_dataOut"}, dataOut, 0);
        chk({tag, "_trackerOut"}, 64'(trackerOut), 0);
        chk({tag, "_msgLength"}, 64'(msgLength), 0);
        chk({tag, "_msgCount"}, 64'(msgCount), 0);
    endtask

    task automatic randomStream(input int n);
        logic [7:0] types[7];
        int         sel, len;
        types = '{8'h41, 8'h45, 8'h43, 8'h44, 8'h55, 8'h54, 8'h00};
        for (int m = 0; m < n; m++) begin
            sel = $urandom_range(0, 19);
            len = sel == 0 ? 0 : sel == 1 ? MAX_LEN : sel == 2 ? MAX_LEN + 1 :
                  sel == 3 ? int'($urandom_range(66, 300)) : sel < 7 ? int'($urandom_range(1, 3)) :
                  int'($urandom_range(1, 40));
            types[6] = 8'($urandom);
            addMsg(len, types[$urandom_range(0, 6)]);
        end
        padStream();
    endtask

    initial begin : monitor
        logic [6:0] obs;
        evT         e;
        forever begin
            @(negedge clk);
            obs = {startOther, startTimeSeconds, startOrderReplace, startOrderDelete,
                   startOrderExecutedPrice, startOrderExecuted, startAddOrder};
            if (rst && (obs != 0 || lenError)) begin
                if (expQ.size() == 0) begin
                    chk("unexpectedPulse", 64'({obs, lenError}), 0);
                end else begin
                    e = expQ.pop_front();
                    chk("startVector", 64'(obs), 64'(e.starts));
                    chk("lenError", 64'(lenError), 64'(e.lenErr));
                    if (e.starts != 0) begin
                        chk("trackerOut", 64'(trackerOut), 64'(e.tracker));
                        chk("dataOut", dataOut, e.word);
                        chk("msgLength", 64'(msgLength), 64'(e.len));
                        chk("msgCount", 64'(msgCount), 64'(e.cnt));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        bus.inValid = 1'b1;
        bus.dataIn  = {$urandom, $urandom};
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chkIdle("reset");
        rst = 1'b1;
        bus.inValid = 1'b0;
        @(negedge clk);

        // delete, fillers, two T in one word, straddled length, unknown type, L=0, oversized L
        addMsg(int'(expectedLength(8'h44)), 8'h44);
        addMsg(2, 8'h5A);
        addMsg(4, 8'h5A);
        addMsg(int'(expectedLength(8'h54)), 8'h54);
        addMsg(int'(expectedLength(8'h54)), 8'h54);
        addMsg(1, 8'h41);
        addMsg(18, 8'h44);
        addMsg(8, 8'h5A);
        addMsg(0, 8'h00);
        addMsg(256, 8'h41);
        addMsg(MAX_LEN, 8'h55);
        addMsg(3, 8'h45);
        addMsg(4, 8'h43);
        padStream();
        driveAll(1 << 20);

        for (int s = 0; s < 6; s++) begin
            randomStream(int'($urandom_range(10, 30)));
            driveAll(1 << 20);
        end

        // reset in the middle of a message body
        addMsg(40, 8'h44);
        padStream();
        driveAll(3);
        chk("pendingBeforeReset", 64'(expQ.size()), 0);
        rst = 1'b0;
        bus.inValid = 1'b1;
        bus.dataIn  = {$urandom, $urandom};
        repeat (2) @(negedge clk);
        chkIdle("midReset");
        rst = 1'b1;
        bus.inValid = 1'b0;
        expQ.delete();
        expCnt = 0;
        @(negedge clk);
        addMsg(10, 8'h41);
        addMsg(18, 8'h44);
        randomStream(15);
        driveAll(1 << 20);

        repeat (3) @(negedge clk);
        chk("pendingEvents", 64'(expQ.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
